// File: rtl/tx_frame_arbiter_if.sv
// Byte-stream bundle between the requesters, the frame arbiter and the tx FIFO write port.
// Handshake: a byte moves on a cycle where valid and ready are both high; valid never waits on ready.
interface tx_frame_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output req_data, req_valid, req_last, out_ready,
    input  req_ready, out_data, out_valid
  );

  modport slave (
    input  req_data, req_valid, req_last, out_ready,
    output req_ready, out_data, out_valid
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the UART tx FIFO write port.
// Optional stall watchdog compiled in with `define TX_ARB_TIMEOUT_EN.
module tx_frame_arbiter #(
  parameter int  NUM_REQ        = 2,
  parameter int  DATA_WIDTH     = 8,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int GNT_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tx_frame_arbiter_if.slave bus,
  output logic [GNT_W-1:0] grant_id,
  output logic             busy,
  output logic             timeout_err
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state;
  logic [GNT_W-1:0] last_gnt;
  logic [GNT_W-1:0] sel;
  logic             found;
  logic             any_req;
  logic             xfer;
  logic             frame_done;
  logic             abort;

  assign any_req = |bus.req_valid;
  assign busy    = (state == S_GRANT);

  // Scan starts just after the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = GNT_W'(idx);
      end
    end
  end

  always_comb begin
    bus.out_data  = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    bus.out_valid = 1'b0;
    bus.req_ready = '0;
    if (busy && !abort) begin
      bus.out_valid           = bus.req_valid[grant_id];
      bus.req_ready[grant_id] = bus.out_ready;
    end
  end

  assign xfer       = bus.out_valid & bus.out_ready;
  assign frame_done = xfer & bus.req_last[grant_id];

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;

  assign abort       = busy && (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err = abort;

  // Idle clears the count, so every new grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!busy || xfer || abort) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant_id <= '0;
      last_gnt <= GNT_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id <= sel;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (frame_done || abort) begin
            last_gnt <= grant_id;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: two requesters, byte scoreboard tagged with grant id.
module tb_tx_frame_arbiter;
  logic       clk;
  logic       rst_n;
  logic [0:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  tx_frame_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus ();

  tx_frame_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // requester driver: head of each queue is presented, popped after a handshake
  initial begin
    logic x0, x1;
    logic [8:0] h;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      x0 = bus.req_valid[0] & bus.req_ready[0];
      x1 = bus.req_valid[1] & bus.req_ready[1];
      @(posedge clk);
      #1;
      if (x0 && q0.size() > 0) void'(q0.pop_front());
      if (x1 && q1.size() > 0) void'(q1.pop_front());
      h = (q0.size() > 0) ? q0[0] : 9'h0;
      bus.req_valid[0]   = (q0.size() > 0);
      bus.req_last[0]    = h[8];
      bus.req_data[7:0]  = h[7:0];
      h = (q1.size() > 0) ? q1[0] : 9'h0;
      bus.req_valid[1]   = (q1.size() > 0);
      bus.req_last[1]    = h[8];
      bus.req_data[15:8] = h[7:0];
    end
  end

  // output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back({grant_id, bus.out_data});
    end
  end

  task automatic add_frame(input int id, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (id == 0) q0.push_back({(i == n - 1), base + 8'(i)});
      else         q1.push_back({(i == n - 1), base + 8'(i)});
    end
  endtask

  task automatic exp_frame(input logic id, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({id, base + 8'(i)});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic sb_check(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_grant", grant_id, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: single 3-byte frame from requester 0
    @(negedge clk);
    add_frame(0, 8'hA1, 3);
    exp_frame(1'b0, 8'hA1, 3);
    @(negedge clk);
    chk("t1_arb_busy", busy, 0);
    chk("t1_arb_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_b0_busy", busy, 1);
    chk("t1_b0_data", {bus.out_valid, bus.out_data}, 9'h1A1);
    chk("t1_b0_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    chk("t1_b1_data", {bus.out_valid, bus.out_data}, 9'h1A2);
    @(negedge clk);
    chk("t1_b2_data", {bus.out_valid, bus.out_data}, 9'h1A3);
    @(negedge clk);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_valid", bus.out_valid, 0);
    chk("t1_grant", grant_id, 0);
    sb_check("t1_sb");

    // 2: both requesters, three 2-byte frames each; last winner was 0 so 1 goes first
    @(negedge clk);
    add_frame(0, 8'h10, 2); add_frame(0, 8'h12, 2); add_frame(0, 8'h14, 2);
    add_frame(1, 8'h20, 2); add_frame(1, 8'h22, 2); add_frame(1, 8'h24, 2);
    exp_frame(1'b1, 8'h20, 2); exp_frame(1'b0, 8'h10, 2);
    exp_frame(1'b1, 8'h22, 2); exp_frame(1'b0, 8'h12, 2);
    exp_frame(1'b1, 8'h24, 2); exp_frame(1'b0, 8'h14, 2);
    wait_idle("t2_done", 100);
    sb_check("t2_sb");

    // 3: requester 0 arrives while requester 1 is mid-frame
    @(negedge clk);
    add_frame(1, 8'h30, 4);
    exp_frame(1'b1, 8'h30, 4);
    exp_frame(1'b0, 8'h40, 2);
    repeat (3) @(negedge clk);
    add_frame(0, 8'h40, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(busy && grant_id == 1'b1)) break;
      chk("t3_hold_r0", bus.req_ready[0], 0);
    end
    wait_idle("t3_done", 50);
    sb_check("t3_sb");

    // 4: tx FIFO full mid-frame
    @(negedge clk);
    add_frame(0, 8'h50, 4);
    exp_frame(1'b0, 8'h50, 4);
    n = 0;
    while (!(bus.out_valid && bus.out_data == 8'h51) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_51", 32'(n < 20), 32'd1);
    @(posedge clk);
    #2 bus.out_ready = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    repeat (10) begin
`else
    repeat (20) begin
`endif
      @(negedge clk);
      chk("t4_stall_data", {bus.out_valid, bus.out_data}, 9'h152);
      chk("t4_stall_grant", {busy, grant_id}, 2'b10);
    end
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    wait_idle("t4_done", 50);
    sb_check("t4_sb");

    // 5: asynchronous reset in the middle of a frame
    @(negedge clk);
    add_frame(1, 8'h60, 3);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_started", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_ready", bus.req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    q0.delete(); q1.delete(); got_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    add_frame(0, 8'h70, 1);
    add_frame(1, 8'h71, 1);
    exp_frame(1'b0, 8'h70, 1);
    exp_frame(1'b1, 8'h71, 1);
    wait_idle("t5_done", 50);
    sb_check("t5_sb");

    // 6: requester 1 sends one byte without last, then goes quiet
    @(negedge clk);
    q1.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, 8'h80});
    n = 0;
    while (!(bus.out_valid && bus.out_ready && bus.out_data == 8'h80) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_byte80", 32'(n < 20), 32'd1);
    add_frame(0, 8'h90, 2);
`ifdef TX_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t6_no_err", {busy, timeout_err}, 2'b10);
    end
    @(negedge clk);
    chk("t6_err_pulse", timeout_err, 1);
    chk("t6_abort_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t6_err_clear", timeout_err, 0);
    chk("t6_idle", busy, 0);
    @(negedge clk);
    chk("t6_regrant", {busy, grant_id}, 2'b10);
`else
    repeat (40) begin
      @(negedge clk);
      chk("t6_hold", {busy, grant_id, timeout_err, bus.req_ready[0]}, 4'b1100);
    end
    q1.push_back({1'b1, 8'h81});
    exp_q.push_back({1'b1, 8'h81});
`endif
    exp_frame(1'b0, 8'h90, 2);
    wait_idle("t6_done", 60);
    sb_check("t6_sb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
